// File: rtl/jtframe_sdram_pkg.sv
// Shared SDRAM definitions: bank count, bank index type and core bus widths,
// plus the request payload held in the arbiter's issue register.
package jtframe_sdram_pkg;

    localparam int unsigned NBANK = 4;
    localparam int unsigned SD_AW = 23;
    localparam int unsigned SD_DW = 32;
    localparam int unsigned SD_WW = 16;
    localparam int unsigned SD_MW = 2;

    typedef logic [1:0] bank_t;

    typedef struct packed {
        logic             rd;
        logic             wr;
        bank_t            ba;
        logic [SD_AW-1:0] addr;
        logic [SD_WW-1:0] din;
        logic [SD_MW-1:0] din_m;
    } sd_req_t;

endpackage

// File: rtl/jtframe_sdram_bank_arb_if.sv
// Client-side and core-side signal bundle of the four-bank SDRAM arbiter.
// master = arbiter view, slave = clients plus bank core.
interface jtframe_sdram_bank_arb_if #(
    parameter int unsigned AW = 22
);
    import jtframe_sdram_pkg::*;

    logic [NBANK*AW-1:0]    cl_addr;
    logic [NBANK-1:0]       cl_rd;
    logic [NBANK-1:0]       cl_wr;
    logic [NBANK*SD_WW-1:0] cl_din;
    logic [NBANK*SD_MW-1:0] cl_din_m;
    logic [NBANK-1:0]       cl_ack;
    logic [NBANK-1:0]       cl_dst;
    logic [SD_DW-1:0]       cl_dout;
    logic                   rfsh_in;

    logic [SD_AW-1:0]       sd_addr;
    logic                   sd_rd;
    logic                   sd_wr;
    bank_t                  sd_ba;
    logic [SD_WW-1:0]       sd_din;
    logic [SD_MW-1:0]       sd_din_m;
    logic                   sd_rfsh_en;
    logic                   sd_ack;
    logic                   sd_rdy;
    bank_t                  sd_ba_rdy;
    logic [SD_DW-1:0]       sd_dout;

    modport master (
        input  cl_addr, cl_rd, cl_wr, cl_din, cl_din_m, rfsh_in,
        input  sd_ack, sd_rdy, sd_ba_rdy, sd_dout,
        output cl_ack, cl_dst, cl_dout,
        output sd_addr, sd_rd, sd_wr, sd_ba, sd_din, sd_din_m, sd_rfsh_en
    );

    modport slave (
        output cl_addr, cl_rd, cl_wr, cl_din, cl_din_m, rfsh_in,
        output sd_ack, sd_rdy, sd_ba_rdy, sd_dout,
        input  cl_ack, cl_dst, cl_dout,
        input  sd_addr, sd_rd, sd_wr, sd_ba, sd_din, sd_din_m, sd_rfsh_en
    );

endinterface

// File: rtl/jtframe_sdram_rr4.sv
// Four-way picker: round-robin starting after ptr, or fixed priority with
// bank 0 highest when prio is set. Purely combinational.
module jtframe_sdram_rr4
    import jtframe_sdram_pkg::*;
(
    input  logic [NBANK-1:0] eligible,
    input  bank_t            ptr,
    input  logic             prio,
    output logic             valid,
    output bank_t            win
);

    bank_t idx;

    // Walk the search order backwards so the first candidate in order wins.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = NBANK - 1; i >= 0; i--) begin
            idx = prio ? bank_t'(i) : bank_t'(ptr + bank_t'(i + 1));
            if (eligible[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_bank_arb.sv
// Four-client arbiter in front of jtframe_sdram_bank_core: one client per bank,
// one outstanding access per bank, read data routed back by the core's ba_rdy tag.
module jtframe_sdram_bank_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int unsigned AW   = 22,
    parameter int unsigned PRIO = 0
)(
    input  logic                    rst,
    input  logic                    clk,
    jtframe_sdram_bank_arb_if.master bus
);

    sd_req_t          req_q, req_d;
    logic [NBANK-1:0] busy, busy_d;
    logic [NBANK-1:0] issued, eligible;
    logic [NBANK-1:0] ack_q, ack_d, dst_q, dst_d;
    logic [SD_DW-1:0] dout_q, dout_d;
    logic             rfsh_q;
    bank_t            ptr, ptr_d, ptr_eff, win;
    logic             win_vld, active, ack_vld, grant_en;

    logic [AW-1:0]    addr_a [NBANK];
    logic [SD_WW-1:0] din_a  [NBANK];
    logic [SD_MW-1:0] mask_a [NBANK];

    for (genvar b = 0; b < NBANK; b++) begin : g_unpack
        assign addr_a[b] = bus.cl_addr[b*AW +: AW];
        assign din_a[b]  = bus.cl_din[b*SD_WW +: SD_WW];
        assign mask_a[b] = bus.cl_din_m[b*SD_MW +: SD_MW];
    end

    // The bank sitting in the issue register is excluded from the search.
    always_comb begin
        issued = '0;
        if (active) issued[req_q.ba] = 1'b1;
    end

    assign active   = req_q.rd | req_q.wr;
    assign ack_vld  = bus.sd_ack & active;
    assign grant_en = ~active | bus.sd_ack;
    assign ptr_eff  = ack_vld ? req_q.ba : ptr;
    assign eligible = (bus.cl_rd | bus.cl_wr) & ~busy & ~issued;

    jtframe_sdram_rr4 u_pick (
        .eligible (eligible),
        .ptr      (ptr_eff),
        .prio     (PRIO != 0),
        .valid    (win_vld),
        .win      (win)
    );

    // Next issue register: held until ack, reloaded from the winner otherwise.
    always_comb begin
        req_d = req_q;
        if (grant_en) begin
            req_d.rd = win_vld & bus.cl_rd[win] & ~bus.cl_wr[win];
            req_d.wr = win_vld & bus.cl_wr[win];
            if (win_vld) begin
                req_d.ba    = win;
                req_d.addr  = SD_AW'(addr_a[win]);
                req_d.din   = din_a[win];
                req_d.din_m = bus.cl_wr[win] ? mask_a[win] : '0;
            end
        end
    end

    // Completion clears busy before acceptance sets it, so both apply together.
    always_comb begin
        busy_d = busy;
        ack_d  = '0;
        dst_d  = '0;
        dout_d = dout_q;
        ptr_d  = ptr;
        if (bus.sd_rdy && busy[bus.sd_ba_rdy]) begin
            busy_d[bus.sd_ba_rdy] = 1'b0;
            dst_d[bus.sd_ba_rdy]  = 1'b1;
            dout_d                = bus.sd_dout;
        end
        if (ack_vld) begin
            busy_d[req_q.ba] = 1'b1;
            ack_d[req_q.ba]  = 1'b1;
            ptr_d            = req_q.ba;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q  <= '0;
            busy   <= '0;
            ack_q  <= '0;
            dst_q  <= '0;
            dout_q <= '0;
            rfsh_q <= 1'b0;
            ptr    <= 2'd3;
        end else begin
            req_q  <= req_d;
            busy   <= busy_d;
            ack_q  <= ack_d;
            dst_q  <= dst_d;
            dout_q <= dout_d;
            rfsh_q <= bus.rfsh_in;
            ptr    <= ptr_d;
        end
    end

    assign bus.sd_rd      = req_q.rd;
    assign bus.sd_wr      = req_q.wr;
    assign bus.sd_ba      = req_q.ba;
    assign bus.sd_addr    = req_q.addr;
    assign bus.sd_din     = req_q.din;
    assign bus.sd_din_m   = req_q.din_m;
    assign bus.sd_rfsh_en = rfsh_q;
    assign bus.cl_ack     = ack_q;
    assign bus.cl_dst     = dst_q;
    assign bus.cl_dout    = dout_q;

endmodule

// File: tb/tb_jtframe_sdram_bank_arb.sv
// Directed bench for the four-bank arbiter; the core side is driven by hand,
// one PRIO=0 and one PRIO=1 instance.
module tb_jtframe_sdram_bank_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jtframe_sdram_bank_arb_if #(.AW(22)) bus0();
    jtframe_sdram_bank_arb_if #(.AW(22)) bus1();

    jtframe_sdram_bank_arb #(.AW(22), .PRIO(0)) dut0 (.rst(rst), .clk(clk), .bus(bus0));
    jtframe_sdram_bank_arb #(.AW(22), .PRIO(1)) dut1 (.rst(rst), .clk(clk), .bus(bus1));

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic       ack;
        logic       rdy;
        logic [1:0] ba_rdy;
        logic       exp_rd;
        logic       exp_wr;
        logic [1:0] exp_ba;
        logic [3:0] exp_ack;
        logic [3:0] exp_dst;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " sd_rd"},      32'(bus0.sd_rd),      32'd0);
        chk({tag, " sd_wr"},      32'(bus0.sd_wr),      32'd0);
        chk({tag, " sd_ba"},      32'(bus0.sd_ba),      32'd0);
        chk({tag, " sd_addr"},    32'(bus0.sd_addr),    32'd0);
        chk({tag, " sd_din"},     32'(bus0.sd_din),     32'd0);
        chk({tag, " sd_din_m"},   32'(bus0.sd_din_m),   32'd0);
        chk({tag, " sd_rfsh_en"}, 32'(bus0.sd_rfsh_en), 32'd0);
        chk({tag, " cl_ack"},     32'(bus0.cl_ack),     32'd0);
        chk({tag, " cl_dst"},     32'(bus0.cl_dst),     32'd0);
        chk({tag, " cl_dout"},    bus0.cl_dout,         32'd0);
    endtask

    initial begin
        logic [31:0] exp_dout;
        logic [31:0] dval;

        bus0.cl_addr = '0; bus0.cl_rd = '0; bus0.cl_wr = '0; bus0.cl_din = '0;
        bus0.cl_din_m = '0; bus0.rfsh_in = 1'b0; bus0.sd_ack = 1'b0; bus0.sd_rdy = 1'b0;
        bus0.sd_ba_rdy = '0; bus0.sd_dout = '0;
        bus1.cl_addr = '0; bus1.cl_rd = '0; bus1.cl_wr = '0; bus1.cl_din = '0;
        bus1.cl_din_m = '0; bus1.rfsh_in = 1'b0; bus1.sd_ack = 1'b0; bus1.sd_rdy = 1'b0;
        bus1.sd_ba_rdy = '0; bus1.sd_dout = '0;

        //                rd       wr       ack   rdy   ba_rdy e_rd  e_wr  e_ba  e_ack    e_dst
        vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 4'b0001, 4'b0000};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 4'b0010, 4'b0000};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd3, 4'b0100, 4'b0001};
        vecs[5]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b1000, 4'b0000};
        vecs[6]  = '{4'b1111, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b1000};
        vecs[7]  = '{4'b1111, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 4'b0001, 4'b0000};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b1000, 4'b0000};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0010};
        vecs[11] = '{4'b0000, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Round-robin fairness, ack/rdy overlap, spurious rdy, write grant
        bus0.rfsh_in = 1'b1;
        exp_dout = '0;
        for (int i = 0; i < 12; i++) begin
            dval = 32'hC0DE_0000 | 32'(i);
            bus0.cl_rd     = vecs[i].rd;
            bus0.cl_wr     = vecs[i].wr;
            bus0.sd_ack    = vecs[i].ack;
            bus0.sd_rdy    = vecs[i].rdy;
            bus0.sd_ba_rdy = vecs[i].ba_rdy;
            bus0.sd_dout   = dval;
            step();
            if (vecs[i].exp_dst != 4'd0) exp_dout = dval;
            chk($sformatf("v%0d sd_rd", i),   32'(bus0.sd_rd),  32'(vecs[i].exp_rd));
            chk($sformatf("v%0d sd_wr", i),   32'(bus0.sd_wr),  32'(vecs[i].exp_wr));
            if (vecs[i].exp_rd || vecs[i].exp_wr)
                chk($sformatf("v%0d sd_ba", i), 32'(bus0.sd_ba), 32'(vecs[i].exp_ba));
            chk($sformatf("v%0d cl_ack", i),  32'(bus0.cl_ack), 32'(vecs[i].exp_ack));
            chk($sformatf("v%0d cl_dst", i),  32'(bus0.cl_dst), 32'(vecs[i].exp_dst));
            chk($sformatf("v%0d cl_dout", i), bus0.cl_dout,     exp_dout);
        end
        bus0.sd_ack = 1'b0; bus0.sd_rdy = 1'b0; bus0.cl_wr = '0; bus0.cl_rd = '0;
        chk("rfsh_en copy", 32'(bus0.sd_rfsh_en), 32'd1);

        // Reset with banks 0, 2, 3 busy and bank 1 issued
        rst = 1'b1;
        #2;
        chk_zero("mid rst");
        bus0.rfsh_in = 1'b0;
        step();
        rst = 1'b0;

        // Single read on bank 0; read ignores the client mask
        bus0.cl_rd = 4'b0001;
        bus0.cl_addr[21:0] = 22'h00123;
        bus0.cl_din_m[1:0] = 2'b11;
        step();
        chk("rd sd_rd",    32'(bus0.sd_rd),    32'd1);
        chk("rd sd_ba",    32'(bus0.sd_ba),    32'd0);
        chk("rd sd_addr",  32'(bus0.sd_addr),  32'h00123);
        chk("rd sd_din_m", 32'(bus0.sd_din_m), 32'd0);
        bus0.cl_rd = 4'b0000;
        bus0.sd_ack = 1'b1;
        step();
        chk("rd cl_ack", 32'(bus0.cl_ack), 32'b0001);
        chk("rd idle",   32'(bus0.sd_rd),  32'd0);
        bus0.sd_ack = 1'b0;
        bus0.sd_rdy = 1'b1; bus0.sd_ba_rdy = 2'd0; bus0.sd_dout = 32'hDEAD_BEEF;
        step();
        chk("rd cl_dst",  32'(bus0.cl_dst), 32'b0001);
        chk("rd cl_dout", bus0.cl_dout,     32'hDEAD_BEEF);
        bus0.sd_rdy = 1'b0;

        // Write on bank 2 wins over read, is held after the client drops it
        bus0.cl_wr = 4'b0100; bus0.cl_rd = 4'b0100;
        bus0.cl_addr[65:44] = 22'h3ABCD;
        bus0.cl_din[47:32]  = 16'hA55A;
        bus0.cl_din_m[5:4]  = 2'b01;
        step();
        chk("wr sd_wr",    32'(bus0.sd_wr),    32'd1);
        chk("wr sd_rd",    32'(bus0.sd_rd),    32'd0);
        chk("wr sd_ba",    32'(bus0.sd_ba),    32'd2);
        chk("wr sd_addr",  32'(bus0.sd_addr),  32'h3ABCD);
        chk("wr sd_din",   32'(bus0.sd_din),   32'hA55A);
        chk("wr sd_din_m", 32'(bus0.sd_din_m), 32'b01);
        bus0.cl_wr = '0; bus0.cl_rd = '0; bus0.cl_din[47:32] = 16'h0000;
        step();
        chk("wr hold sd_wr",  32'(bus0.sd_wr),  32'd1);
        chk("wr hold sd_din", 32'(bus0.sd_din), 32'hA55A);
        bus0.sd_ack = 1'b1;
        step();
        chk("wr cl_ack", 32'(bus0.cl_ack), 32'b0100);
        chk("wr idle",   32'(bus0.sd_wr),  32'd0);
        bus0.sd_ack = 1'b0;
        bus0.sd_rdy = 1'b1; bus0.sd_ba_rdy = 2'd2; bus0.sd_dout = 32'h5555_AAAA;
        step();
        chk("wr cl_dst", 32'(bus0.cl_dst), 32'b0100);
        bus0.sd_rdy = 1'b0;

        // Busy blocking on bank 0, spurious rdy on idle bank 3
        bus0.cl_rd = 4'b0001;
        step();
        chk("bb grant", 32'(bus0.sd_rd), 32'd1);
        bus0.sd_ack = 1'b1;
        step();
        chk("bb cl_ack",  32'(bus0.cl_ack), 32'b0001);
        chk("bb blocked", 32'(bus0.sd_rd),  32'd0);
        bus0.sd_ack = 1'b0;
        step();
        chk("bb still blocked", 32'(bus0.sd_rd), 32'd0);
        bus0.sd_rdy = 1'b1; bus0.sd_ba_rdy = 2'd3; bus0.sd_dout = 32'h1234_5678;
        step();
        chk("spurious cl_dst",  32'(bus0.cl_dst), 32'd0);
        chk("spurious cl_dout", bus0.cl_dout,     32'h5555_AAAA);
        bus0.sd_ba_rdy = 2'd0; bus0.sd_dout = 32'hCAFE_F00D;
        step();
        chk("bb cl_dst",   32'(bus0.cl_dst), 32'b0001);
        chk("bb cl_dout",  bus0.cl_dout,     32'hCAFE_F00D);
        chk("bb same cyc", 32'(bus0.sd_rd),  32'd0);
        bus0.sd_rdy = 1'b0;
        step();
        chk("bb regrant rd", 32'(bus0.sd_rd), 32'd1);
        chk("bb regrant ba", 32'(bus0.sd_ba), 32'd0);
        bus0.cl_rd = '0;

        // Fixed priority: bank 1 before 3, then bank 0 jumps ahead of 3
        bus1.cl_rd = 4'b1010;
        step();
        chk("p1 sd_rd", 32'(bus1.sd_rd), 32'd1);
        chk("p1 ba1",   32'(bus1.sd_ba), 32'd1);
        bus1.cl_rd = 4'b1011;
        bus1.sd_ack = 1'b1;
        step();
        chk("p1 ack1", 32'(bus1.cl_ack), 32'b0010);
        chk("p1 ba0",  32'(bus1.sd_ba),  32'd0);
        step();
        chk("p1 ack0", 32'(bus1.cl_ack), 32'b0001);
        chk("p1 ba3",  32'(bus1.sd_ba),  32'd3);
        step();
        chk("p1 ack3", 32'(bus1.cl_ack), 32'b1000);
        chk("p1 idle", 32'(bus1.sd_rd),  32'd0);
        bus1.sd_ack = 1'b0;
        bus1.cl_rd = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
